// File: rtl/dual_port_ram_param.sv
// Parametrised single-clock true dual-port RAM with byte-lane writes and a post-reset zero-fill sequencer.
// Ports: clk/rst_n; busy (init running); per port en/we/ad/din in, out/val out; coll (same-address double write).
// Latency: READ_LAT (1 or 2) cycles from request capture to out/val. No backpressure: every accepted read produces one val.
module dual_port_ram_param #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 4,
    parameter int READ_LAT    = 1,
    parameter int RDW_NEW     = 0,
    parameter int INIT_ON_RST = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  busy,
    input  logic                  ena,
    input  logic [DATA_W/8-1:0]   wea,
    input  logic [ADDR_W-1:0]     ada,
    input  logic [DATA_W-1:0]     dina,
    output logic [DATA_W-1:0]     outa,
    output logic                  vala,
    input  logic                  enb,
    input  logic [DATA_W/8-1:0]   web,
    input  logic [ADDR_W-1:0]     adb,
    input  logic [DATA_W-1:0]     dinb,
    output logic [DATA_W-1:0]     outb,
    output logic                  valb,
    output logic                  coll
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    // Overwrite the lanes of 'old' selected by 'we' with the matching lanes of 'din'.
    function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old,
                                                     input logic [DATA_W-1:0] din,
                                                     input logic [NB-1:0]     we);
        logic [DATA_W-1:0] r;
        r = old;
        for (int i = 0; i < NB; i++) begin
            if (we[i]) r[8*i +: 8] = din[8*i +: 8];
        end
        return r;
    endfunction

    // Init sequencer: walks every address once, then parks in READY until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= (INIT_ON_RST != 0) ? ST_INIT : ST_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) state_d = ST_READY;
        end
    end

    assign busy = (state_q == ST_INIT);

    logic wr_a, rd_a, wr_b, rd_b, same_ad;
    assign wr_a    = !busy && ena && (|wea);
    assign rd_a    = !busy && ena && !(|wea);
    assign wr_b    = !busy && enb && (|web);
    assign rd_b    = !busy && enb && !(|web);
    assign same_ad = (ada == adb);

    // merged_x is the stored word with the other port's same-cycle write folded in.
    // A's write data is built on top of B's merge so A wins overlapping lanes.
    logic [DATA_W-1:0] word_a, word_b, merged_a, merged_b, wdat_a, wdat_b, rdat_a, rdat_b;
    always_comb begin
        word_a   = mem[ada];
        word_b   = mem[adb];
        merged_a = (same_ad && wr_b) ? lane_merge(word_a, dinb, web) : word_a;
        merged_b = (same_ad && wr_a) ? lane_merge(word_b, dina, wea) : word_b;
        wdat_a   = lane_merge(merged_a, dina, wea);
        wdat_b   = lane_merge(word_b, dinb, web);
        rdat_a   = (RDW_NEW != 0) ? merged_a : word_a;
        rdat_b   = (RDW_NEW != 0) ? merged_b : word_b;
    end

    // Storage has no reset; the sequencer provides the zero fill.
    // On a same-address double write the A assignment comes last and carries B's lanes.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt_q] <= '0;
        end else begin
            if (wr_b) mem[adb] <= wdat_b;
            if (wr_a) mem[ada] <= wdat_a;
        end
    end

    // First read stage: data register only loads on a read so the output holds between reads.
    logic [DATA_W-1:0] d1a_q, d1b_q;
    logic              v1a_q, v1b_q, coll_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1a_q  <= '0;
            d1b_q  <= '0;
            v1a_q  <= 1'b0;
            v1b_q  <= 1'b0;
            coll_q <= 1'b0;
        end else begin
            v1a_q  <= rd_a;
            v1b_q  <= rd_b;
            coll_q <= wr_a && wr_b && same_ad;
            if (rd_a) d1a_q <= rdat_a;
            if (rd_b) d1b_q <= rdat_b;
        end
    end
    assign coll = coll_q;

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] d2a_q, d2b_q;
            logic              v2a_q, v2b_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d2a_q <= '0;
                    d2b_q <= '0;
                    v2a_q <= 1'b0;
                    v2b_q <= 1'b0;
                end else begin
                    v2a_q <= v1a_q;
                    v2b_q <= v1b_q;
                    if (v1a_q) d2a_q <= d1a_q;
                    if (v1b_q) d2b_q <= d1b_q;
                end
            end
            assign outa = d2a_q;
            assign vala = v2a_q;
            assign outb = d2b_q;
            assign valb = v2b_q;
        end else begin : g_lat1
            assign outa = d1a_q;
            assign vala = v1a_q;
            assign outb = d1b_q;
            assign valb = v1b_q;
        end
    endgenerate
endmodule
